// File: rtl/scg_pkg.sv
// Shared definitions for the SDRAM command generator (scg_*) blocks.
// Command encodings are the {cs_n, ras_n, cas_n, we_n} bus values driven
// onto the SDRAM command pins by the controller top.
package scg_pkg;

    localparam int unsigned CMD_BITS = 4;

    localparam logic [CMD_BITS-1:0] CMD_NOP       = 4'b0111;
    localparam logic [CMD_BITS-1:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [CMD_BITS-1:0] CMD_AUTO_REF  = 4'b0001;

endpackage : scg_pkg

// File: rtl/scg_self_ref_entry.sv
// Self-refresh entry sequencer.
// On start: PRECHARGE ALL, wait T_RP cycles, SELF REFRESH (AUTO REFRESH with
// CKE low), wait T_CKE cycles, then signal done.  After done, CKE stays low
// (HOLD) until wake; the exit sequence is handled by scg_self_ref_exit.
// Ports:
//   clk      - clock, all state changes on posedge
//   rst      - synchronous active-high reset
//   start    - level request, held until done is seen
//   wake     - ends the CKE-low hold (only looked at in DONE/HOLD)
//   done     - high in the DONE state only
//   command  - {cs_n, ras_n, cas_n, we_n}
//   a10      - address bit 10, high during PRECHARGE ALL
//   cke      - SDRAM clock enable, low from SELF REFRESH through HOLD
module scg_self_ref_entry
    import scg_pkg::*;
#(
    parameter int unsigned CNT_BITS = 4,
    parameter int unsigned T_RP     = 2,
    parameter int unsigned T_CKE    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                wake,
    output logic                done,
    output logic [CMD_BITS-1:0] command,
    output logic                a10,
    output logic                cke
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECH,
        S_WAIT_RP,
        S_SREF,
        S_WAIT_CKE,
        S_DONE,
        S_HOLD
    } state_t;

    // Terminal counts: the counter starts at 0 on entry to a wait state, so
    // hitting N-1 means N cycles have been spent there.
    localparam logic [CNT_BITS-1:0] RP_LAST  = CNT_BITS'(T_RP - 1);
    localparam logic [CNT_BITS-1:0] CKE_LAST = CNT_BITS'(T_CKE - 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_next;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic.  The counter only advances while staying in a wait
    // state; every other path (including leaving a wait state) clears it.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_PRECH;
            end
            S_PRECH: begin
                state_next = S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (cnt == RP_LAST) state_next = S_SREF;
                else                cnt_next   = cnt + CNT_BITS'(1);
            end
            S_SREF: begin
                state_next = S_WAIT_CKE;
            end
            S_WAIT_CKE: begin
                if (cnt == CKE_LAST) state_next = S_DONE;
                else                 cnt_next   = cnt + CNT_BITS'(1);
            end
            S_DONE: begin
                // wake only counts once start has been released.
                if (!start) state_next = wake ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (wake) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore outputs.
    always_comb begin
        command = CMD_NOP;
        a10     = 1'b0;
        cke     = 1'b1;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
            end
            S_PRECH: begin
                command = CMD_PRECHARGE;
                a10     = 1'b1;
            end
            S_WAIT_RP: begin
            end
            S_SREF: begin
                command = CMD_AUTO_REF;
                cke     = 1'b0;
            end
            S_WAIT_CKE: begin
                cke = 1'b0;
            end
            S_DONE: begin
                cke  = 1'b0;
                done = 1'b1;
            end
            S_HOLD: begin
                cke = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule : scg_self_ref_entry

// File: tb/tb_scg_self_ref_entry.sv
// Scoreboard bench for scg_self_ref_entry: two instances (default timing and
// T_RP=5/T_CKE=3) share the same stimulus.  Each has a timeline model that
// pushes the expected {command,a10,cke,done} for the next cycle; a monitor
// pops and compares once per cycle.
module tb_scg_self_ref_entry;

    localparam int unsigned RP0  = 2;
    localparam int unsigned CK0  = 1;
    localparam int unsigned RP1  = 5;
    localparam int unsigned CK1  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic wake = 1'b0;

    logic       done0, a10_0, cke0;
    logic [3:0] command0;
    logic       done1, a10_1, cke1;
    logic [3:0] command1;

    always #5 clk = ~clk;

    scg_self_ref_entry #(.CNT_BITS(4), .T_RP(RP0), .T_CKE(CK0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .wake(wake),
        .done(done0), .command(command0), .a10(a10_0), .cke(cke0)
    );

    scg_self_ref_entry #(.CNT_BITS(4), .T_RP(RP1), .T_CKE(CK1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .wake(wake),
        .done(done1), .command(command1), .a10(a10_1), .cke(cke1)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q0[$];
    logic [6:0] exp_q1[$];

    // Model view: 0 = idle (CKE high), 1 = running sequence at position pos
    // (pos 1 is the PRECHARGE cycle, pos 3+T_RP+T_CKE is done), 2 = CKE held low.
    int mode[2];
    int pos[2];

    function automatic logic [6:0] expected(int m, int p, int rp, int ck);
        logic [6:0] r;
        r = {4'b0111, 1'b0, 1'b1, 1'b0};
        if (m == 2) begin
            r = {4'b0111, 1'b0, 1'b0, 1'b0};
        end else if (m == 1) begin
            if (p == 1)                r = {4'b0010, 1'b1, 1'b1, 1'b0};
            else if (p <= 1 + rp)      r = {4'b0111, 1'b0, 1'b1, 1'b0};
            else if (p == 2 + rp)      r = {4'b0001, 1'b0, 1'b0, 1'b0};
            else if (p <= 2 + rp + ck) r = {4'b0111, 1'b0, 1'b0, 1'b0};
            else                       r = {4'b0111, 1'b0, 1'b0, 1'b1};
        end
        return r;
    endfunction

    task automatic model_step(int i, int rp, int ck, logic s, logic w, logic r);
        int last;
        last = 3 + rp + ck;
        if (r) begin
            mode[i] = 0;
            pos[i]  = 0;
        end else if (mode[i] == 0) begin
            if (s) begin
                mode[i] = 1;
                pos[i]  = 1;
            end
        end else if (mode[i] == 1) begin
            if (pos[i] < last)  pos[i] = pos[i] + 1;
            else if (!s)        mode[i] = w ? 0 : 2;
        end else begin
            if (w) mode[i] = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what each DUT
    // must show after the following rising edge.
    task automatic drive(logic s, logic w, logic r);
        @(negedge clk);
        start = s;
        wake  = w;
        rst   = r;
        model_step(0, RP0, CK0, s, w, r);
        model_step(1, RP1, CK1, s, w, r);
        exp_q0.push_back(expected(mode[0], pos[0], RP0, CK0));
        exp_q1.push_back(expected(mode[1], pos[1], RP1, CK1));
    endtask

    task automatic repeat_drive(int n, logic s, logic w);
        for (int k = 0; k < n; k++) drive(s, w, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle; compare just after the edge.
    initial begin
        logic [6:0] e;
        logic [6:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                a = {command0, a10_0, cke0, done0};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL dut0_outputs t=%0t got cmd/a10/cke/done=%b/%b/%b/%b want %b/%b/%b/%b",
                             $time, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
                end
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                a = {command1, a10_1, cke1, done1};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL dut1_outputs t=%0t got cmd/a10/cke/done=%b/%b/%b/%b want %b/%b/%b/%b",
                             $time, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        mode[0] = 0; pos[0] = 0;
        mode[1] = 0; pos[1] = 0;

        drive(1'b0, 1'b0, 1'b1);            // reset
        repeat_drive(2, 1'b0, 1'b0);

        // Full sequence with start held, then release into HOLD, later wake.
        repeat_drive(14, 1'b1, 1'b0);
        repeat_drive(3, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);            // start in HOLD is ignored
        drive(1'b0, 1'b1, 1'b0);            // wake -> IDLE
        repeat_drive(2, 1'b0, 1'b0);

        // Reset in the middle of the RP wait, then a fresh sequence.
        repeat_drive(2, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        repeat_drive(14, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);            // DONE with wake -> IDLE directly
        repeat_drive(2, 1'b0, 1'b0);

        // Single-cycle start pulse: sequence still completes, one-cycle done.
        drive(1'b1, 1'b0, 1'b0);
        repeat_drive(14, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // wake held high throughout: ignored until start drops in DONE.
        repeat_drive(14, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        repeat_drive(2, 1'b0, 1'b0);

        // Randomized stretch.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 59) == 0));
        end

        repeat_drive(3, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_scg_self_ref_entry
